// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light controller:
//   - state_e     : phase state encoding (value is exported on the phase port)
//   - LAMP_*      : lamp patterns in {red,yellow,green} order
//   - TIMER_W     : width of the phase timer / remain port
//   - next_phase(): cyclic successor in the normal (non-flash) phase ring
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // FLASH is not part of the ring; it falls back to ALL_RED_A.
    function automatic state_e next_phase(input state_e s);
        case (s)
            ALL_RED_A: next_phase = NS_GREEN;
            NS_GREEN:  next_phase = NS_YELLOW;
            NS_YELLOW: next_phase = ALL_RED_B;
            ALL_RED_B: next_phase = EW_GREEN;
            EW_GREEN:  next_phase = EW_YELLOW;
            default:   next_phase = ALL_RED_A;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_if
// Control inputs and lamp/status outputs of the traffic light controller.
//   enable   : run; low freezes the whole controller
//   night    : flash mode request
//   ped_req  : pedestrian button (level, synchronised)
//   ns_light : north-south lamps {red,yellow,green}
//   ew_light : east-west lamps {red,yellow,green}
//   phase    : current state encoding
//   remain   : ticks left in phase minus one
// Modports: master drives the control inputs, slave is the controller.
// -----------------------------------------------------------------------------
interface traffic_light_ctrl_if;
    import traffic_pkg::*;

    logic               enable;
    logic               night;
    logic               ped_req;
    logic [2:0]         ns_light;
    logic [2:0]         ew_light;
    logic [2:0]         phase;
    logic [TIMER_W-1:0] remain;

    modport master (
        output enable, night, ped_req,
        input  ns_light, ew_light, phase, remain
    );

    modport slave (
        input  enable, night, ped_req,
        output ns_light, ew_light, phase, remain
    );

endinterface

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks.
//   clk20M : system clock
//   Reset  : asynchronous, active-high; clears the count
//   enable : low holds the count and suppresses tick
//   tick   : high on the cycle where the count equals TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clk20M,
    input  logic Reset,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk20M or posedge Reset) begin
        if (Reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
// Two-road intersection phase sequencer with night flash mode.
//   clk20M : system clock (20 MHz)
//   Reset  : asynchronous, active-high
//   tl     : traffic_light_ctrl_if.slave (enable, night, ped_req in;
//            ns_light, ew_light, phase, remain out)
// Optional feature macro: PED_REQ_EN -- a latched pedestrian request shortens
// the remaining green to SHORT_T ticks. Without it ped_req is ignored.
// -----------------------------------------------------------------------------
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 20000000,
    parameter int GREEN_T  = 25,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int SHORT_T  = 5
) (
    input  logic                 clk20M,
    input  logic                 Reset,
    traffic_light_ctrl_if.slave  tl
);
    localparam logic [TIMER_W-1:0] SHORT_LD = TIMER_W'(SHORT_T - 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               blink_q, blink_d;
    logic               tick;
    logic               ped_pending;
    logic [2:0]         ns_light, ew_light;

    // Timer load value on entry to a state (duration minus one).
    function automatic logic [TIMER_W-1:0] phase_len(input state_e s);
        case (s)
            NS_GREEN, EW_GREEN:   phase_len = TIMER_W'(GREEN_T - 1);
            NS_YELLOW, EW_YELLOW: phase_len = TIMER_W'(YELLOW_T - 1);
            default:              phase_len = TIMER_W'(ALLRED_T - 1);
        endcase
    endfunction

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk20M (clk20M),
        .Reset  (Reset),
        .enable (tl.enable),
        .tick   (tick)
    );

    // tick is already gated by enable, so nothing moves while enable is low.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        blink_d = blink_q;
        if (tick) begin
            if (tl.night) begin
                if (state_q == FLASH) begin
                    blink_d = ~blink_q;
                end else begin
                    state_d = FLASH;
                    blink_d = 1'b0;
                end
            end else if (state_q == FLASH) begin
                state_d = ALL_RED_A;
                timer_d = phase_len(ALL_RED_A);
            end else if (ped_pending && (state_q == NS_GREEN || state_q == EW_GREEN)
                         && (timer_q > SHORT_LD)) begin
                timer_d = SHORT_LD;
            end else if (timer_q != '0) begin
                timer_d = timer_q - TIMER_W'(1);
            end else begin
                state_d = next_phase(state_q);
                timer_d = phase_len(next_phase(state_q));
            end
        end
    end

    always_ff @(posedge clk20M or posedge Reset) begin
        if (Reset) begin
            state_q <= ALL_RED_A;
            timer_q <= phase_len(ALL_RED_A);
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
        end
    end

`ifdef PED_REQ_EN
    logic ped_pending_q, ped_pending_d;
    logic enter_all_red;

    // Entering an all-red phase drops the old request; a press on the same
    // cycle still registers for the next green.
    assign enter_all_red = (state_d != state_q) &&
                           (state_d == ALL_RED_A || state_d == ALL_RED_B);

    always_comb begin
        ped_pending_d = enter_all_red ? 1'b0 : ped_pending_q;
        if (tl.enable && tl.ped_req) ped_pending_d = 1'b1;
    end

    always_ff @(posedge clk20M or posedge Reset) begin
        if (Reset) ped_pending_q <= 1'b0;
        else       ped_pending_q <= ped_pending_d;
    end

    assign ped_pending = ped_pending_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = tl.ped_req;
    assign ped_pending    = 1'b0;
`endif

    // Moore lamp decode from registered state only.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state_q)
            NS_GREEN:  ns_light = LAMP_GRN;
            NS_YELLOW: ns_light = LAMP_YEL;
            EW_GREEN:  ew_light = LAMP_GRN;
            EW_YELLOW: ew_light = LAMP_YEL;
            FLASH: begin
                ns_light = blink_q ? LAMP_YEL : LAMP_OFF;
                ew_light = blink_q ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
    end

    assign tl.ns_light = ns_light;
    assign tl.ew_light = ew_light;
    assign tl.phase    = state_q;
    assign tl.remain   = timer_q;

endmodule
